// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the reboot request block.
// Holds the FSM state encoding and the I/O boot magic value.
package boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FIRE,
        ST_DONE
    } state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hB0;

endpackage

// File: rtl/sync2.sv
// sync2: 1-bit two-flop synchronizer, async active-low reset.
// Ports: clk, rst_n, d (async in), q (synced out, 2 clocks later).
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/boot_request.sv
// boot_request: key-combo / CPU-port reboot request generator.
// Ports: clock, reset (async, active-low), combo (async level),
//   io_wr/io_sel/io_data (CPU boot port), boot (pulse), busy.
// Macro BOOT_IO_EN enables the CPU port trigger (data == BOOT_MAGIC).
module boot_request
    import boot_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES  = 24'd7000000,
    parameter logic [7:0]  PULSE_CYCLES = 8'd8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       combo,
    input  logic       io_wr,
    input  logic       io_sel,
    input  logic [7:0] io_data,
    output logic       boot,
    output logic       busy
);

    localparam logic [7:0] PULSE_LAST = PULSE_CYCLES - 8'd1;

    logic combo_s;

    sync2 u_sync (
        .clk   (clock),
        .rst_n (reset),
        .d     (combo),
        .q     (combo_s)
    );

    logic io_trig;

`ifdef BOOT_IO_EN
    logic trig_q;
    logic trig_d;

    assign trig_d = io_wr && io_sel && (io_data == BOOT_MAGIC);

    // One register stage keeps the outputs free of any input path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign io_trig = trig_q;
`else
    logic unused_io;

    assign unused_io = ^{io_wr, io_sel, io_data};
    assign io_trig   = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [23:0] hold_q, hold_d;
    logic [7:0]  pulse_q, pulse_d;
    logic        boot_q, boot_d;
    logic        busy_q, busy_d;
    logic        hold_done;

    // The clock entering HOLD is the first held sample, so the
    // count reaches HOLD_CYCLES-1 on this clock when hold_q+1 does.
    assign hold_done = ({1'b0, hold_q} + 25'd2) >= {1'b0, HOLD_CYCLES};

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pulse_d = pulse_q;
        boot_d  = boot_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io_trig) begin
                    state_d = ST_FIRE;
                end else if (combo_s) begin
                    state_d = ST_HOLD;
                    hold_d  = 24'd0;
                end
            end
            ST_HOLD: begin
                if (io_trig) begin
                    state_d = ST_FIRE;
                end else if (!combo_s) begin
                    state_d = ST_IDLE;
                    hold_d  = 24'd0;
                end else if (hold_done) begin
                    state_d = ST_FIRE;
                end else begin
                    hold_d = hold_q + 24'd1;
                end
            end
            ST_FIRE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = ST_DONE;
                    boot_d  = 1'b0;
                end else begin
                    pulse_d = pulse_q + 8'd1;
                end
            end
            ST_DONE: begin
                boot_d = 1'b0;
            end
        endcase
        // Entry into FIRE, from either trigger source.
        if (state_d == ST_FIRE && state_q != ST_FIRE) begin
            hold_d  = 24'd0;
            pulse_d = 8'd0;
            boot_d  = 1'b1;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 24'd0;
            pulse_q <= 8'd0;
            boot_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            boot_q  <= boot_d;
            busy_q  <= busy_d;
        end
    end

    assign boot = boot_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_boot_request.sv
// tb_boot_request: directed bench for boot_request with a
// run-length reference model checked on every clock.
module tb_boot_request;

    localparam int HOLD  = 100;
    localparam int PULSE = 8;
`ifdef BOOT_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       combo = 1'b0;
    logic       io_wr = 1'b0;
    logic       io_sel = 1'b0;
    logic [7:0] io_data = 8'h00;
    logic       boot;
    logic       busy;

    always #5 clock = ~clock;

    boot_request #(
        .HOLD_CYCLES  (24'd100),
        .PULSE_CYCLES (8'd8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .combo   (combo),
        .io_wr   (io_wr),
        .io_sel  (io_sel),
        .io_data (io_data),
        .boot    (boot),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the request fires once a synced combo run
    // reaches HOLD samples, or one clock after a valid port write;
    // afterwards boot is high PULSE clocks and busy stays high.
    int cyc = 0;
    int fire_cyc = -1;
    int run = 0;
    bit p0 = 1'b0;
    bit p1 = 1'b0;
    bit io_prev = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            run = 0;
            p0 = 1'b0;
            p1 = 1'b0;
            io_prev = 1'b0;
            fire_cyc = -1;
        end else begin
            cyc = cyc + 1;
            run = p1 ? run + 1 : 0;
            p1 = p0;
            p0 = combo;
            if (fire_cyc < 0 && (run >= HOLD || io_prev))
                fire_cyc = cyc;
            io_prev = IO_EN && io_wr && io_sel && io_data == 8'hB0;
        end
    end

    always @(negedge clock) begin
        logic eb;
        logic ey;
        if (reset) begin
            eb = fire_cyc >= 0 && (cyc - fire_cyc) < PULSE;
            ey = fire_cyc >= 0;
            checks++;
            if (boot !== eb || busy !== ey) begin
                errors++;
                $display("FAIL model cyc=%0d boot=%b busy=%b required boot=%b busy=%b",
                         cyc, boot, busy, eb, ey);
            end
        end
    end

    // Pulse monitor used by the literal checks.
    int rises = 0;
    int hi_cnt = 0;
    int rise_cyc = 0;
    bit boot_prev = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            rises = 0;
            hi_cnt = 0;
            boot_prev = 1'b0;
        end else begin
            if (boot && !boot_prev) begin
                rises++;
                rise_cyc = cyc;
            end
            if (boot) hi_cnt++;
            boot_prev = boot;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        combo = 1'b0;
        io_wr = 1'b0;
        io_sel = 1'b0;
        io_data = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic io_write(input logic [7:0] d);
        io_wr = 1'b1;
        io_sel = 1'b1;
        io_data = d;
        @(negedge clock);
        io_wr = 1'b0;
        io_sel = 1'b0;
        io_data = 8'h00;
    endtask

    int start;
    bit seen;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_boot", int'(boot), 0);
        check("reset_busy", int'(busy), 0);
        #1 reset = 1'b1;
        @(negedge clock);

        // Combo held 200 clocks.
        start = cyc;
        combo = 1'b1;
        ncyc(200);
        combo = 1'b0;
        ncyc(20);
        check("s1_rises", rises, 1);
        check("s1_delay", rise_cyc - start, 102);
        check("s1_width", hi_cnt, 8);
        check("s1_busy", int'(busy), 1);

        // 99 held, 5 released, then 200 held.
        do_reset();
        combo = 1'b1;
        ncyc(99);
        combo = 1'b0;
        ncyc(5);
        check("s2_no_pulse", rises, 0);
        check("s2_not_busy", int'(busy), 0);
        start = cyc;
        combo = 1'b1;
        ncyc(200);
        combo = 1'b0;
        ncyc(5);
        check("s2_rises", rises, 1);
        check("s2_delay", rise_cyc - start, 102);

        // CPU port writes.
        do_reset();
        start = cyc;
        io_write(8'hB0);
        ncyc(15);
`ifdef BOOT_IO_EN
        check("s3_rises", rises, 1);
        check("s3_delay", rise_cyc - start, 2);
        check("s3_width", hi_cnt, 8);
        check("s3_busy", int'(busy), 1);
        do_reset();
        io_write(8'hB1);
        ncyc(15);
        check("s3_b1_rises", rises, 0);
        check("s3_b1_busy", int'(busy), 0);
`else
        check("s3_off_rises", rises, 0);
        check("s3_off_busy", int'(busy), 0);
        start = cyc;
        combo = 1'b1;
        ncyc(150);
        combo = 1'b0;
        ncyc(5);
        check("s3_off_delay", rise_cyc - start, 102);
        check("s3_off_rises2", rises, 1);
`endif

        // Combo held 1000 clocks with extra writes while done.
        do_reset();
        start = cyc;
        combo = 1'b1;
        ncyc(150);
        repeat (3) begin
            io_write(8'hB0);
            ncyc(50);
        end
        ncyc(697);
        combo = 1'b0;
        ncyc(10);
        check("s4_rises", rises, 1);
        check("s4_width", hi_cnt, 8);
        check("s4_delay", rise_cyc - start, 102);

        // Reset in the fourth pulse clock.
        do_reset();
        combo = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (boot) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL s5_wait boot never rose within 200 clocks");
        end
        ncyc(3);
        check("s5_pre_boot", int'(boot), 1);
        #2 reset = 1'b0;
        #1;
        check("s5_async_boot", int'(boot), 0);
        check("s5_async_busy", int'(busy), 0);
        combo = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        ncyc(5);
        check("s5_idle_busy", int'(busy), 0);
        start = cyc;
        combo = 1'b1;
        ncyc(120);
        combo = 1'b0;
        ncyc(5);
        check("s5_rises", rises, 1);
        check("s5_delay", rise_cyc - start, 102);

`ifdef BOOT_IO_EN
        // Port trigger on the same clock as the hold expiry.
        do_reset();
        start = cyc;
        combo = 1'b1;
        ncyc(100);
        io_write(8'hB0);
        ncyc(30);
        combo = 1'b0;
        ncyc(5);
        check("s6_rises", rises, 1);
        check("s6_width", hi_cnt, 8);
        check("s6_delay", rise_cyc - start, 102);
`endif

        ncyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
